pkt_router_pipelined: RTL and testbench

Parametrised, pipelined successor to the combinational packet router. It looks up each incoming packet's key in a ternary (key/mask) routing table with NUM_RREGS entries and forwards the packet to one of NUM_CHANNELS registered output channels. Packets that miss the table are dropped, as are packets blocked longer than a programmable wait. Routed and dropped events are reported as counter-enable pulses. It sits between the packet input path and the per-channel HSSL transmit queues.

---
 rtl/pkt_router_pipelined_if.sv | 44 ++++
 rtl/pkt_router_pipelined.sv | 158 +++++++++++++++
 tb/tb_pkt_router_pipelined.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_router_pipelined_if.sv
// ---------------------------------------------------------------------------
// pkt_router_pipelined_if
//   Packet handshake bundle between the packet input path, the router and the
//   per-channel transmit queues.
//
//   pkt_in_data_in    PACKET_BITS                 packet offered to the router
//   pkt_in_vld_in     1                           input valid
//   pkt_in_rdy_out    1                           router can accept this cycle
//   pkt_out_data_out  NUM_CHANNELS x PACKET_BITS  per-channel output packet
//   pkt_out_vld_out   NUM_CHANNELS                per-channel output valid
//   pkt_out_rdy_in    NUM_CHANNELS                per-channel downstream ready
//
//   master: the side that feeds packets in and drains the channels.
//   slave : the router itself.
// ---------------------------------------------------------------------------
interface pkt_router_pipelined_if #(
    parameter int PACKET_BITS  = 72,
    parameter int NUM_CHANNELS = 8
);
    logic [PACKET_BITS-1:0]                    pkt_in_data_in;
    logic                                      pkt_in_vld_in;
    logic                                      pkt_in_rdy_out;
    logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0]  pkt_out_data_out;
    logic [NUM_CHANNELS-1:0]                   pkt_out_vld_out;
    logic [NUM_CHANNELS-1:0]                   pkt_out_rdy_in;

    modport master (
        output pkt_in_data_in,
        output pkt_in_vld_in,
        output pkt_out_rdy_in,
        input  pkt_in_rdy_out,
        input  pkt_out_data_out,
        input  pkt_out_vld_out
    );

    modport slave (
        input  pkt_in_data_in,
        input  pkt_in_vld_in,
        input  pkt_out_rdy_in,
        output pkt_in_rdy_out,
        output pkt_out_data_out,
        output pkt_out_vld_out
    );
endinterface

// File: rtl/pkt_router_pipelined.sv
// ---------------------------------------------------------------------------
// pkt_router_pipelined
//   Pipelined ternary-table packet router. Each accepted packet is looked up
//   against NUM_RREGS key/mask entries (lowest index wins) and forwarded into
//   one of NUM_CHANNELS registered output slots. Table misses are dropped, as
//   are packets blocked on a busy channel for reg_drop_wait_in cycles.
//
//   clk               clock, rising edge
//   reset_n           synchronous active-low reset
//   reg_key_in        NUM_RREGS x 32  table keys
//   reg_mask_in       NUM_RREGS x 32  table masks
//   reg_route_in      NUM_RREGS x RW  destination channel per entry
//   reg_drop_wait_in  32              blocked-packet timeout, 0 = wait forever
//   bus               packet handshakes (slave side of the interface)
//   rt_cnt_out        one-cycle pulse per routed packet
//   dr_cnt_out        one-cycle pulse per dropped packet
// ---------------------------------------------------------------------------
module pkt_router_pipelined #(
    parameter int  PACKET_BITS  = 72,
    parameter int  NUM_RREGS    = 16,
    parameter int  KEY_LSB      = 8,
    parameter int  NUM_CHANNELS = 8,
    localparam int RW           = $clog2(NUM_CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_RREGS-1:0][31:0]     reg_key_in,
    input  logic [NUM_RREGS-1:0][31:0]     reg_mask_in,
    input  logic [NUM_RREGS-1:0][RW-1:0]   reg_route_in,
    input  logic [31:0]                    reg_drop_wait_in,
    pkt_router_pipelined_if.slave          bus,
    output logic                           rt_cnt_out,
    output logic                           dr_cnt_out
);

    typedef enum logic {
        S1_IDLE,
        S1_WAIT
    } s1_state_t;

    s1_state_t                                 s1_state;
    logic                                      s1_vld;
    logic [PACKET_BITS-1:0]                    s1_data;
    logic                                      s1_hit;
    logic [RW-1:0]                             s1_route;
    logic [31:0]                               wait_cnt;

    logic [NUM_CHANNELS-1:0]                   out_vld;
    logic [NUM_CHANNELS-1:0][PACKET_BITS-1:0]  out_data;

    logic [31:0]                               in_key;
    logic                                      lk_hit;
    logic [RW-1:0]                             lk_route;
    logic [NUM_CHANNELS-1:0]                   out_free;
    logic [31:0]                               cur_wait;
    logic                                      s1_blocked;
    logic                                      s1_fwd;
    logic                                      s1_timeout;
    logic                                      s1_drop;
    logic                                      s1_leaves;
    logic                                      accept;

    assign in_key = bus.pkt_in_data_in[KEY_LSB +: 32];

    // Table lookup on the incoming packet. Walking from the top index down
    // lets the lowest-indexed hit overwrite the others. An entry whose key has
    // bits outside its mask can never match, which is how entries are
    // disabled. A winning route that names a non-existent channel is a miss.
    always_comb begin
        lk_hit   = 1'b0;
        lk_route = '0;
        for (int e = NUM_RREGS - 1; e >= 0; e--) begin
            if ((in_key & reg_mask_in[e]) == reg_key_in[e]) begin
                lk_hit   = 1'b1;
                lk_route = reg_route_in[e];
            end
        end
        if (int'(lk_route) >= NUM_CHANNELS) begin
            lk_hit = 1'b0;
        end
    end

    // A channel slot can take a packet if it is empty or is being drained
    // this very cycle. The wait count only means something while in WAIT.
    assign out_free   = ~out_vld | bus.pkt_out_rdy_in;
    assign cur_wait   = (s1_state == S1_WAIT) ? wait_cnt : 32'd0;
    assign s1_blocked = s1_vld && s1_hit && !out_free[s1_route];
    assign s1_fwd     = s1_vld && s1_hit && out_free[s1_route];
    assign s1_timeout = s1_blocked && (reg_drop_wait_in != 32'd0)
                        && (cur_wait == reg_drop_wait_in - 32'd1);
    assign s1_drop    = s1_vld && (!s1_hit || s1_timeout);
    assign s1_leaves  = s1_fwd || s1_drop;

    assign bus.pkt_in_rdy_out = reset_n && (!s1_vld || s1_leaves);
    assign accept             = bus.pkt_in_vld_in && bus.pkt_in_rdy_out;

    // Lookup register and its IDLE/WAIT controller. The table result is
    // frozen at accept, so later table writes never retarget a held packet.
    // A new packet may be captured in the same cycle the old one leaves,
    // which is what keeps the input at one packet per cycle. The event
    // pulses are registered here so they are glitch-free; forward and drop
    // are mutually exclusive, so the two pulses never coincide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_state   <= S1_IDLE;
            s1_vld     <= 1'b0;
            s1_data    <= '0;
            s1_hit     <= 1'b0;
            s1_route   <= '0;
            wait_cnt   <= '0;
            rt_cnt_out <= 1'b0;
            dr_cnt_out <= 1'b0;
        end else begin
            rt_cnt_out <= s1_fwd;
            dr_cnt_out <= s1_drop;

            if (accept) begin
                s1_vld   <= 1'b1;
                s1_data  <= bus.pkt_in_data_in;
                s1_hit   <= lk_hit;
                s1_route <= lk_route;
            end else if (s1_leaves) begin
                s1_vld   <= 1'b0;
            end

            if (s1_blocked && !s1_timeout) begin
                s1_state <= S1_WAIT;
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end else begin
                s1_state <= S1_IDLE;
                wait_cnt <= '0;
            end
        end
    end

    // Per-channel output slots. A slot that is drained and refilled in the
    // same cycle stays valid, allowing back-to-back packets on one channel.
    // Data is only ever written on a fill, so it holds until the transfer.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (!reset_n) begin
                out_vld[c]  <= 1'b0;
                out_data[c] <= '0;
            end else if (s1_fwd && (s1_route == RW'(c))) begin
                out_vld[c]  <= 1'b1;
                out_data[c] <= s1_data;
            end else if (bus.pkt_out_rdy_in[c]) begin
                out_vld[c]  <= 1'b0;
            end
        end
    end

    assign bus.pkt_out_vld_out  = out_vld;
    assign bus.pkt_out_data_out = out_data;

endmodule

// File: tb/tb_pkt_router_pipelined.sv
// ---------------------------------------------------------------------------
// tb_pkt_router_pipelined
//   Directed bench for pkt_router_pipelined. Stimulus pushes the expected
//   channel/data of each routed packet into a queue; an independent monitor
//   pops the first entry for a channel whenever that channel transfers, and
//   also tracks pulse counts and output hold stability.
// ---------------------------------------------------------------------------
module tb_pkt_router_pipelined;

    localparam int PB = 72;
    localparam int NR = 16;
    localparam int NC = 8;
    localparam int RW = 3;

    typedef struct {
        logic [RW-1:0] ch;
        logic [PB-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NR-1:0][31:0]  reg_key;
    logic [NR-1:0][31:0]  reg_mask;
    logic [NR-1:0][RW-1:0] reg_route;
    logic [31:0]          drop_wait;
    logic                 rt_cnt;
    logic                 dr_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    int rt_seen = 0, dr_seen = 0, delivered = 0;
    int exp_rt  = 0, exp_dr  = 0;
    int cycle   = 0;
    exp_t exp_q[$];

    pkt_router_pipelined_if #(.PACKET_BITS(PB), .NUM_CHANNELS(NC)) bus();

    pkt_router_pipelined #(
        .PACKET_BITS (PB),
        .NUM_RREGS   (NR),
        .KEY_LSB     (8),
        .NUM_CHANNELS(NC)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .reg_key_in      (reg_key),
        .reg_mask_in     (reg_mask),
        .reg_route_in    (reg_route),
        .reg_drop_wait_in(drop_wait),
        .bus             (bus),
        .rt_cnt_out      (rt_cnt),
        .dr_cnt_out      (dr_cnt)
    );

    // Free-running clock and an edge counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, "_rt_pulses"}, 128'(rt_seen), 128'(exp_rt));
        checkOutput({tag, "_dr_pulses"}, 128'(dr_seen), 128'(exp_dr));
        checkOutput({tag, "_pending"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic clearTable();
        for (int e = 0; e < NR; e++) begin
            reg_key[e]   = 32'hFFFF_FFFF;
            reg_mask[e]  = 32'h0000_0000;
            reg_route[e] = '0;
        end
    endtask

    task automatic setEntry(input int e, input logic [31:0] key,
                            input logic [31:0] mask, input logic [RW-1:0] route);
        reg_key[e]   = key;
        reg_mask[e]  = mask;
        reg_route[e] = route;
    endtask

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    // Offers one packet (caller sits just after a rising edge) and holds it
    // until accepted; returns how many cycles the router stalled it. The
    // expected outcome is recorded at the accept edge.
    task automatic applyStimulus(input logic [31:0] key, input logic [31:0] tag,
                                 input int exp_ch, input bit exp_drop,
                                 output int waited);
        exp_t e;
        bit   ok;
        waited = 0;
        ok     = 1'b0;
        bus.pkt_in_data_in = {tag, key, tag[7:0]};
        bus.pkt_in_vld_in  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (bus.pkt_in_rdy_out) begin
                ok = 1'b1;
                break;
            end
            waited++;
            syncEdge();
        end
        if (!ok) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept for key 0x%0h", key);
        end
        syncEdge();
        bus.pkt_in_vld_in = 1'b0;
        if (ok) begin
            if (exp_drop) begin
                exp_dr++;
            end else begin
                exp_rt++;
                e.ch   = RW'(exp_ch);
                e.data = {tag, key, tag[7:0]};
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: pulse bookkeeping, hold stability and scoreboard compare on
    // every channel transfer (vld && rdy seen mid-cycle, out of reset).
    initial begin
        logic [NC-1:0]         prev_hold;
        logic [NC-1:0][PB-1:0] prev_data;
        int                    idx;
        prev_hold = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rt_cnt || dr_cnt) begin
                checkOutput("pulse_exclusive", 128'(rt_cnt && dr_cnt), 128'd0);
            end
            if (rt_cnt) rt_seen++;
            if (dr_cnt) dr_seen++;
            for (int c = 0; c < NC; c++) begin
                if (prev_hold[c] && reset_n) begin
                    checkOutput("hold_stable",
                                {55'd0, bus.pkt_out_vld_out[c], bus.pkt_out_data_out[c]},
                                {55'd0, 1'b1, prev_data[c]});
                end
                if (reset_n && bus.pkt_out_vld_out[c] && bus.pkt_out_rdy_in[c]) begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && int'(exp_q[i].ch) == c) idx = i;
                    end
                    if (idx < 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_output ch%0d: got 0x%0h, expected nothing",
                                 c, bus.pkt_out_data_out[c]);
                    end else begin
                        checkOutput("out_data", 128'(bus.pkt_out_data_out[c]),
                                    128'(exp_q[idx].data));
                        exp_q.delete(idx);
                        delivered++;
                    end
                end
                prev_hold[c] = reset_n && bus.pkt_out_vld_out[c] && !bus.pkt_out_rdy_in[c];
                prev_data[c] = bus.pkt_out_data_out[c];
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int w, tot, t0, r0, d0, d_rdy;
        logic [PB-1:0] pkt_a;

        clearTable();
        drop_wait          = 32'd0;
        bus.pkt_in_vld_in  = 1'b0;
        bus.pkt_in_data_in = '0;
        bus.pkt_out_rdy_in = '1;

        // Reset state.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_vld",      128'(bus.pkt_out_vld_out), 128'd0);
        checkOutput("reset_data",     128'(|bus.pkt_out_data_out), 128'd0);
        checkOutput("reset_rt",       128'(rt_cnt), 128'd0);
        checkOutput("reset_dr",       128'(dr_cnt), 128'd0);
        checkOutput("reset_in_rdy",   128'(bus.pkt_in_rdy_out), 128'd0);
        syncEdge();
        reset_n = 1'b1;
        repeat (2) syncEdge();

        // 1: basic route and latency. Packet driven just after edge k,
        // accepted at k+1, visible on channel 5 from k+2.
        $display("[TB] test 1: basic route");
        setEntry(3, 32'h1234_0000, 32'hFFFF_0000, 3'd5);
        t0 = cycle;
        applyStimulus(32'h1234_ABCD, 32'hA5A5_0001, 5, 1'b0, w);
        checkOutput("t1_accept_edge", 128'(cycle - t0), 128'd1);
        @(negedge clk);
        checkOutput("t1_vld_at_k1", 128'(bus.pkt_out_vld_out), 128'd0);
        @(negedge clk);
        checkOutput("t1_vld_at_k2", 128'(bus.pkt_out_vld_out), 128'h20);
        checkOutput("t1_data_at_k2", 128'(bus.pkt_out_data_out[5]),
                    128'({32'hA5A5_0001, 32'h1234_ABCD, 8'h01}));
        checkOutput("t1_rt_at_k2", 128'(rt_cnt), 128'd1);
        syncEdge();
        repeat (4) syncEdge();
        checkCounts("t1");

        // 2: two matching entries; the lower index (route 2) wins.
        $display("[TB] test 2: priority");
        clearTable();
        setEntry(1, 32'h0, 32'h0, 3'd2);
        setEntry(7, 32'h0, 32'h0, 3'd6);
        applyStimulus(32'hDEAD_BEEF, 32'hB000_0001, 2, 1'b0, w);
        applyStimulus(32'h0000_0000, 32'hB000_0002, 2, 1'b0, w);
        applyStimulus(32'hFFFF_FFFF, 32'hB000_0003, 2, 1'b0, w);
        repeat (5) syncEdge();
        checkCounts("t2");

        // 3: every entry disabled, four back-to-back misses.
        $display("[TB] test 3: miss");
        clearTable();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h5000_0000 + i, 32'hC000_0000 + i, 0, 1'b1, w);
            checkOutput("t3_no_stall", 128'(w), 128'd0);
        end
        repeat (4) syncEdge();
        checkCounts("t3");

        // 4: timeout of 10 with channel 5 stalled. A parks in the output
        // slot, B sits blocked in the lookup register and is dropped on its
        // tenth blocked cycle.
        $display("[TB] test 4: timeout");
        clearTable();
        setEntry(0, 32'h0, 32'h0, 3'd5);
        drop_wait = 32'd10;
        bus.pkt_out_rdy_in[5] = 1'b0;
        pkt_a = {32'hD000_000A, 32'h0000_0A0A, 8'h0A};
        applyStimulus(32'h0000_0A0A, 32'hD000_000A, 5, 1'b0, w);
        applyStimulus(32'h0000_0B0B, 32'hD000_000B, 5, 1'b1, w);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput("t4_in_rdy", 128'(bus.pkt_in_rdy_out), (i == 10) ? 128'd1 : 128'd0);
            checkOutput("t4_dr_early", 128'(dr_cnt), 128'd0);
        end
        @(negedge clk);
        checkOutput("t4_dr_pulse", 128'(dr_cnt), 128'd1);
        checkOutput("t4_a_held_vld", 128'(bus.pkt_out_vld_out[5]), 128'd1);
        checkOutput("t4_a_held_data", 128'(bus.pkt_out_data_out[5]), 128'(pkt_a));
        syncEdge();
        bus.pkt_out_rdy_in[5] = 1'b1;
        drop_wait = 32'd0;
        repeat (4) syncEdge();
        checkCounts("t4");

        // 5: timeout disabled, channel 0 stalled for 1000 cycles.
        $display("[TB] test 5: no timeout");
        clearTable();
        setEntry(0, 32'h0, 32'h0, 3'd0);
        bus.pkt_out_rdy_in[0] = 1'b0;
        pkt_a = {32'hE000_0001, 32'h0000_0E01, 8'h01};
        applyStimulus(32'h0000_0E01, 32'hE000_0001, 0, 1'b0, w);
        applyStimulus(32'h0000_0E02, 32'hE000_0002, 0, 1'b0, w);
        d_rdy = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.pkt_in_rdy_out) d_rdy++;
        end
        checkOutput("t5_in_rdy_cycles", 128'(d_rdy), 128'd0);
        checkOutput("t5_held_data", 128'(bus.pkt_out_data_out[0]), 128'(pkt_a));
        checkOutput("t5_no_drops", 128'(dr_seen), 128'(exp_dr));
        syncEdge();
        bus.pkt_out_rdy_in[0] = 1'b1;
        repeat (5) syncEdge();
        checkCounts("t5");

        // 6a: 32 back-to-back packets alternating channels 0 and 1.
        $display("[TB] test 6: throughput and reset");
        clearTable();
        setEntry(0, 32'h0, 32'h1, 3'd0);
        setEntry(1, 32'h1, 32'h1, 3'd1);
        tot = 0;
        t0  = cycle;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(32'(i), 32'h6000_0000 + i, i % 2, 1'b0, w);
            tot += w;
        end
        checkOutput("t6_stalls", 128'(tot), 128'd0);
        checkOutput("t6_cycles", 128'(cycle - t0), 128'd32);
        repeat (4) syncEdge();
        checkCounts("t6a");

        // 6b: reset right after the tenth packet is accepted. p0..p7 have
        // transferred, p8 sits in an output slot (its rt pulse already
        // issued), p9 is still in the lookup register and is never routed.
        r0 = rt_seen;
        d0 = delivered;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'(i), 32'h6100_0000 + i, i % 2, 1'b0, w);
        end
        reset_n = 1'b0;
        checkOutput("t6_inflight", 128'(exp_q.size()), 128'd2);
        exp_q.delete();
        exp_rt = exp_rt - 1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_rst_vld",    128'(bus.pkt_out_vld_out), 128'd0);
        checkOutput("t6_rst_data",   128'(|bus.pkt_out_data_out), 128'd0);
        checkOutput("t6_rst_pulses", 128'({rt_cnt, dr_cnt}), 128'd0);
        checkOutput("t6_rst_in_rdy", 128'(bus.pkt_in_rdy_out), 128'd0);
        checkOutput("t6_delivered",  128'(delivered - d0), 128'd8);
        syncEdge();
        syncEdge();
        reset_n = 1'b1;
        repeat (5) syncEdge();
        checkOutput("t6_rt_after_rst", 128'(rt_seen - r0), 128'd9);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'(i), 32'h6200_0000 + i, i % 2, 1'b0, w);
        end
        repeat (5) syncEdge();
        checkCounts("t6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
